// File: rtl/sort_pkg.sv
// Shared defaults and state type for the sorted-result reader.
// Holds DW/DEPTH/AW defaults and the reader FSM state enum.
package sort_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    FIN  = 3'd4
  } rd_state_e;

endpackage

// File: rtl/sort_edge_detect.sv
// Registered rising-edge detector with async active-low reset.
// Ports: clk, rst_n, d_i (level in), rise_o (1-cycle rise flag).
module sort_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;
  logic armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      d_q     <= d_i;
      armed_q <= 1'b1;
    end
  end

  // No edge until one real sample has been taken after reset,
  // so a level already high at release is not a trigger.
  assign rise_o = armed_q & d_i & ~d_q;

endmodule

// File: rtl/sort_result_reader.sv
// Streams DEPTH words out of the sorter RAM on a done_in rising edge.
// Ports: clk, rst_n, done_in, ram_rd_en/ram_addr/ram_rdata (RAM read,
// 1-cycle latency), out_data/out_valid/out_ready/out_last (byte
// stream), busy, dump_done. Macro SORT_READ_DESCEND_EN reverses the
// address order (DEPTH-1 down to 0).
module sort_result_reader
  import sort_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          done_in,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          dump_done
);

`ifdef SORT_READ_DESCEND_EN
  localparam logic [AW-1:0] ADDR_FIRST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_LAST  = '0;
`else
  localparam logic [AW-1:0] ADDR_FIRST = '0;
  localparam logic [AW-1:0] ADDR_LAST  = AW'(DEPTH - 1);
`endif

  rd_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          trig;
  logic          at_last;
  logic [AW-1:0] addr_step;

  sort_edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (done_in),
    .rise_o (trig)
  );

  assign at_last = (addr_q == ADDR_LAST);

`ifdef SORT_READ_DESCEND_EN
  assign addr_step = addr_q - AW'(1);
`else
  assign addr_step = addr_q + AW'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = READ;
          addr_d  = ADDR_FIRST;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        data_d  = ram_rdata;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = FIN;
          end else begin
            addr_d  = addr_step;
            state_d = READ;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ram_rd_en = (state_q == READ);
  assign ram_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = (state_q == HOLD);
  assign out_last  = (state_q == HOLD) & at_last;
  assign dump_done = (state_q == FIN);
  assign busy      = (state_q == READ) |
                     (state_q == WAIT) |
                     (state_q == HOLD);

endmodule

// File: tb/tb_sort_result_reader.sv
// Self-checking bench for sort_result_reader.
// Queue model of expected bytes/addresses plus directed scenarios.
module tb_sort_result_reader;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

`ifdef SORT_READ_DESCEND_EN
  localparam bit DESC = 1'b1;
`else
  localparam bit DESC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          done_in = 1'b0;
  logic          out_ready = 1'b0;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          dump_done;

  always #5 clk = ~clk;

  sort_result_reader #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .done_in   (done_in),
    .ram_rd_en (ram_rd_en),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .dump_done (dump_done)
  );

  logic [DW-1:0] ram [DEPTH];

  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= ram[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] exp_q[$];
  int            exp_a[$];
  int            recv_cnt = 0;
  int            done_cnt = 0;
  int            stall_cnt = 0;
  logic [DW-1:0] first_b = '0;
  logic [DW-1:0] last_b = '0;

  task automatic load_model();
    int idx;
    exp_q.delete();
    exp_a.delete();
    for (int i = 0; i < DEPTH; i++) begin
      idx = DESC ? (DEPTH - 1 - i) : i;
      exp_q.push_back(ram[idx]);
      exp_a.push_back(idx);
    end
  endtask

  // Compare process: every falling edge
  initial begin : monitor
    bit            hold_pend;
    logic [DW-1:0] hold_data;
    logic          hold_lastv;
    bit            last_hs;
    logic [DW-1:0] e;
    hold_pend  = 0;
    hold_data  = '0;
    hold_lastv = 1'b0;
    last_hs    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 0;
        last_hs   = 0;
      end else begin
        if (ram_rd_en) begin
          if (exp_a.size() == 0) check("unexpected_read", 1, 0);
          else check("ram_addr", ram_addr, exp_a.pop_front());
        end
        check("dump_done_pulse", dump_done, last_hs);
        if (dump_done) begin
          done_cnt++;
          check("busy_at_done", busy, 0);
        end
        last_hs = 0;
        if (out_valid) begin
          check("busy_with_valid", busy, 1);
          if (hold_pend) begin
            check("hold_data", out_data, hold_data);
            check("hold_last", out_last, hold_lastv);
          end
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              check("extra_byte", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("out_data", out_data, e);
              check("out_last", out_last, exp_q.size() == 0);
              if (recv_cnt == 0) first_b = out_data;
              last_b = out_data;
              recv_cnt++;
              last_hs = (exp_q.size() == 0);
            end
            hold_pend = 0;
          end else begin
            stall_cnt++;
            hold_pend  = 1;
            hold_data  = out_data;
            hold_lastv = out_last;
          end
        end else begin
          check("last_without_valid", out_last, 0);
          hold_pend = 0;
        end
      end
    end
  end

  task automatic start_dump();
    load_model();
    recv_cnt = 0;
    done_in  = 1'b1;
  endtask

  task automatic wait_recv(int n);
    int k;
    k = 0;
    while (recv_cnt < n && k < 200) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      k++;
    end
    if (recv_cnt < n) check("wait_recv_timeout", recv_cnt, n);
  endtask

  task automatic wait_dump(bit toggle, int base);
    int k;
    k = 0;
    while (done_cnt == base && k < 300) begin
      @(posedge clk);
      #1;
      out_ready = toggle ? ~out_ready : 1'b1;
      k++;
    end
    check("dump_count", done_cnt - base, 1);
    check("byte_count", recv_cnt, DEPTH);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_rd_en"}, ram_rd_en, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, dump_done, 0);
  endtask

  initial begin : stim
    int base;
    ram[0] = 8'h03; ram[1] = 8'h07; ram[2] = 8'h0A; ram[3] = 8'h11;
    ram[4] = 8'h22; ram[5] = 8'h40; ram[6] = 8'h80; ram[7] = 8'hFF;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // pin the model itself
    load_model();
    check("model_first", exp_q[0], DESC ? 8'hFF : 8'h03);
    check("model_last", exp_q[DEPTH-1], DESC ? 8'h03 : 8'hFF);
    check("model_addr0", exp_a[0], DESC ? 7 : 0);

    // 1: ready high, done_in held high throughout
    out_ready = 1'b1;
    base = done_cnt;
    start_dump();
    wait_dump(1'b0, base);
    check("t1_first", first_b, DESC ? 8'hFF : 8'h03);
    check("t1_last", last_b, DESC ? 8'h03 : 8'hFF);
    repeat (12) @(posedge clk);
    #1;
    check("held_one_dump", done_cnt - base, 1);
    check("held_idle_busy", busy, 0);
    done_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 2: ready toggling every cycle
    out_ready = 1'b0;
    base = done_cnt;
    stall_cnt = 0;
    start_dump();
    @(posedge clk);
    #1 done_in = 1'b0;
    wait_dump(1'b1, base);
    check("t2_stalls_seen", stall_cnt > 0, 1);
    check("t2_last", last_b, DESC ? 8'h03 : 8'hFF);
    repeat (3) @(posedge clk);
    #1;

    // 3: second rising edge at byte 3 is ignored
    out_ready = 1'b1;
    base = done_cnt;
    start_dump();
    @(posedge clk);
    #1 done_in = 1'b0;
    wait_recv(3);
    done_in = 1'b1;
    @(posedge clk);
    #1 done_in = 1'b0;
    wait_dump(1'b0, base);
    repeat (12) @(posedge clk);
    #1;
    check("t3_one_dump", done_cnt - base, 1);
    check("t3_idle_busy", busy, 0);

    // 4: reset at byte 5, done_in high across release
    base = done_cnt;
    start_dump();
    @(posedge clk);
    #1 done_in = 1'b0;
    wait_recv(5);
    rst_n   = 1'b0;
    done_in = 1'b1;
    exp_q.delete();
    exp_a.delete();
    @(negedge clk);
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t4_no_restart", busy, 0);
    check("t4_no_done", done_cnt - base, 0);
    done_in = 1'b0;
    @(posedge clk);
    #1;
    base = done_cnt;
    start_dump();
    @(posedge clk);
    #1 done_in = 1'b0;
    wait_dump(1'b0, base);
    check("t4_first", first_b, DESC ? 8'hFF : 8'h03);
    check("t4_last", last_b, DESC ? 8'h03 : 8'hFF);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
